// File: rtl/cpu_sequencer.sv
// ---------------------------------------------------------------------------
// cpu_sequencer
//
// Control sequencer for a small accumulator-style CPU. It walks each
// instruction through FETCH -> LOAD_IR -> DECODE and then, depending on the
// opcode, through MEM/WB (loads and stores) or EXEC (ALU op and jumps).
// HLT parks the sequencer in HALT until reset.
//
// Ports
//   clk          sole clock, rising edge
//   rst          asynchronous, active-high reset
//   instr        current instruction register contents (opcode in top bits)
//   flags        flag register, flags[0] = zero flag
//   mem_ready    memory completes the outstanding read/write this cycle
//   mem_rd       memory read request, held until mem_ready
//   mem_wr       memory write request, held until mem_ready
//   load_en      one-cycle register load strobe
//   load_select  target register for load_en (LOAD_PC/IR/REG_A/REG_B/REG_C)
//   pc_inc       one-cycle program counter increment strobe
//   alu_op       latched opcode driven to the ALU
//   illegal      one-cycle pulse when an undefined opcode is decoded
//   halted       high while in HALT
//   retired      count of completed instructions (wraps)
// ---------------------------------------------------------------------------
module cpu_sequencer #(
    parameter int WORD_SIZE   = 19,
    parameter int OPCODE_SIZE = 5,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WORD_SIZE-1:0]   instr,
    input  logic [3:0]             flags,
    input  logic                   mem_ready,
    output logic                   mem_rd,
    output logic                   mem_wr,
    output logic                   load_en,
    output logic [2:0]             load_select,
    output logic                   pc_inc,
    output logic [OPCODE_SIZE-1:0] alu_op,
    output logic                   illegal,
    output logic                   halted,
    output logic [CNT_WIDTH-1:0]   retired
);

    // Register select codes seen by the datapath.
    localparam logic [2:0] LOAD_PC    = 3'b000;
    localparam logic [2:0] LOAD_IR    = 3'b001;
    localparam logic [2:0] LOAD_REG_A = 3'b010;
    localparam logic [2:0] LOAD_REG_B = 3'b011;
    localparam logic [2:0] LOAD_REG_C = 3'b100;

    localparam logic [OPCODE_SIZE-1:0] OP_NOP = OPCODE_SIZE'('h00);
    localparam logic [OPCODE_SIZE-1:0] OP_LDA = OPCODE_SIZE'('h01);
    localparam logic [OPCODE_SIZE-1:0] OP_LDB = OPCODE_SIZE'('h02);
    localparam logic [OPCODE_SIZE-1:0] OP_LDC = OPCODE_SIZE'('h03);
    localparam logic [OPCODE_SIZE-1:0] OP_STA = OPCODE_SIZE'('h04);
    localparam logic [OPCODE_SIZE-1:0] OP_ADD = OPCODE_SIZE'('h05);
    localparam logic [OPCODE_SIZE-1:0] OP_JMP = OPCODE_SIZE'('h06);
    localparam logic [OPCODE_SIZE-1:0] OP_JZ  = OPCODE_SIZE'('h07);
    localparam logic [OPCODE_SIZE-1:0] OP_HLT = OPCODE_SIZE'('h1F);

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_LOAD_IR = 3'd1,
        S_DECODE  = 3'd2,
        S_MEM     = 3'd3,
        S_WB      = 3'd4,
        S_EXEC    = 3'd5,
        S_HALT    = 3'd6
    } state_t;

    state_t                 state_q, state_d;
    logic [OPCODE_SIZE-1:0] op_q, op_d;
    logic [CNT_WIDTH-1:0]   retired_q, retired_d;

    logic                   retire;
    logic                   mem_rd_c;
    logic                   mem_wr_c;
    logic                   load_en_c;
    logic [2:0]             load_select_c;
    logic                   pc_inc_c;
    logic                   illegal_c;
    logic                   halted_c;

    logic [OPCODE_SIZE-1:0] opcode;
    assign opcode = instr[WORD_SIZE-1 -: OPCODE_SIZE];

    // Operand bits and the upper flags are not used by the sequencer.
    logic unused_bits;
    assign unused_bits = ^{flags[3:1], instr[WORD_SIZE-OPCODE_SIZE-1:0]};

    // -----------------------------------------------------------------------
    // State, latched opcode and retire counter
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FETCH;
            op_q      <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            retired_q <= retired_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next state and strobes
    // -----------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        retire        = 1'b0;
        mem_rd_c      = 1'b0;
        mem_wr_c      = 1'b0;
        load_en_c     = 1'b0;
        load_select_c = LOAD_PC;
        pc_inc_c      = 1'b0;
        illegal_c     = 1'b0;
        halted_c      = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_rd_c = 1'b1;
                if (mem_ready) begin
                    state_d = S_LOAD_IR;
                end
            end

            S_LOAD_IR: begin
                load_en_c     = 1'b1;
                load_select_c = LOAD_IR;
                pc_inc_c      = 1'b1;
                state_d       = S_DECODE;
            end

            // The IR only holds the new instruction from this cycle on, so
            // branching and the illegal pulse look at instr directly while
            // the opcode is captured into op_q for the following states.
            S_DECODE: begin
                op_d = opcode;
                case (opcode)
                    OP_NOP: begin
                        state_d = S_FETCH;
                        retire  = 1'b1;
                    end
                    OP_LDA, OP_LDB, OP_LDC, OP_STA: begin
                        state_d = S_MEM;
                    end
                    OP_ADD, OP_JMP, OP_JZ: begin
                        state_d = S_EXEC;
                    end
                    OP_HLT: begin
                        state_d = S_HALT;
                        retire  = 1'b1;
                    end
                    default: begin
                        illegal_c = 1'b1;
                        state_d   = S_FETCH;
                        retire    = 1'b1;
                    end
                endcase
            end

            S_MEM: begin
                if (op_q == OP_STA) begin
                    mem_wr_c = 1'b1;
                end else begin
                    mem_rd_c = 1'b1;
                end
                if (mem_ready) begin
                    if (op_q == OP_STA) begin
                        state_d = S_FETCH;
                        retire  = 1'b1;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end

            S_WB: begin
                load_en_c = 1'b1;
                case (op_q)
                    OP_LDA:  load_select_c = LOAD_REG_A;
                    OP_LDB:  load_select_c = LOAD_REG_B;
                    default: load_select_c = LOAD_REG_C;
                endcase
                state_d = S_FETCH;
                retire  = 1'b1;
            end

            S_EXEC: begin
                case (op_q)
                    OP_ADD: begin
                        load_en_c     = 1'b1;
                        load_select_c = LOAD_REG_C;
                    end
                    OP_JMP: begin
                        load_en_c     = 1'b1;
                        load_select_c = LOAD_PC;
                    end
                    OP_JZ: begin
                        // Branch taken only when the zero flag is set now.
                        load_en_c     = flags[0];
                        load_select_c = LOAD_PC;
                    end
                    default: begin
                        load_en_c = 1'b0;
                    end
                endcase
                state_d = S_FETCH;
                retire  = 1'b1;
            end

            S_HALT: begin
                halted_c = 1'b1;
            end

            default: begin
                state_d = S_FETCH;
            end
        endcase

        retired_d = retire ? (retired_q + CNT_WIDTH'(1)) : retired_q;
    end

    // -----------------------------------------------------------------------
    // Outputs. The state register resets to FETCH, which on its own would
    // raise mem_rd; every strobe is therefore masked while rst is high so a
    // reset in the middle of an access drops the request immediately.
    // -----------------------------------------------------------------------
    assign mem_rd      = mem_rd_c  & ~rst;
    assign mem_wr      = mem_wr_c  & ~rst;
    assign load_en     = load_en_c & ~rst;
    assign load_select = rst ? LOAD_PC : load_select_c;
    assign pc_inc      = pc_inc_c  & ~rst;
    assign illegal     = illegal_c & ~rst;
    assign halted      = halted_c  & ~rst;
    assign alu_op      = op_q;
    assign retired     = retired_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_cpu_sequencer
//
// Directed bench for cpu_sequencer. Each instruction is expanded into its
// expected cycle-by-cycle timeline (memory waits, load strobes, retire
// point); a compare process checks every DUT output against that timeline on
// the falling edge. A few literal checks pin retire counts, read-hold length
// and halt behaviour. The retire counter is built 8 bits wide so the wrap
// can be reached with a short run of NOPs.
// ---------------------------------------------------------------------------
module tb_cpu_sequencer;

    localparam int WS = 19;
    localparam int OS = 5;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [WS-1:0] instr;
    logic [3:0]    flags;
    logic          mem_ready;
    logic          mem_rd;
    logic          mem_wr;
    logic          load_en;
    logic [2:0]    load_select;
    logic          pc_inc;
    logic [OS-1:0] alu_op;
    logic          illegal;
    logic          halted;
    logic [CW-1:0] retired;

    cpu_sequencer #(
        .WORD_SIZE   (WS),
        .OPCODE_SIZE (OS),
        .CNT_WIDTH   (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .instr       (instr),
        .flags       (flags),
        .mem_ready   (mem_ready),
        .mem_rd      (mem_rd),
        .mem_wr      (mem_wr),
        .load_en     (load_en),
        .load_select (load_select),
        .pc_inc      (pc_inc),
        .alu_op      (alu_op),
        .illegal     (illegal),
        .halted      (halted),
        .retired     (retired)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int rd_cnt = 0;

    // Expected outputs for the current cycle.
    logic          exp_valid = 1'b0;
    logic          e_rd, e_wr, e_le, e_pc, e_ill, e_hlt;
    logic [2:0]    e_ls;
    logic [OS-1:0] e_alu;
    logic [CW-1:0] e_ret;

    // Model state.
    logic [OS-1:0] m_alu;
    logic [CW-1:0] m_ret;

    task automatic chk(input string name, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, act, want, $time);
        end
    endtask

    // Compare process: every cycle with a defined expectation.
    always @(negedge clk) begin
        if (exp_valid) begin
            chk("mem_rd",  int'(mem_rd),  int'(e_rd));
            chk("mem_wr",  int'(mem_wr),  int'(e_wr));
            chk("load_en", int'(load_en), int'(e_le));
            if (e_le || rst) chk("load_select", int'(load_select), int'(e_ls));
            chk("pc_inc",  int'(pc_inc),  int'(e_pc));
            chk("illegal", int'(illegal), int'(e_ill));
            chk("halted",  int'(halted),  int'(e_hlt));
            chk("alu_op",  int'(alu_op),  int'(e_alu));
            chk("retired", int'(retired), int'(e_ret));
            if (mem_rd) rd_cnt++;
        end
    end

    // One clock cycle: drive mem_ready, publish expectations, advance.
    task automatic cyc(input logic mr, input logic rd, input logic wr,
                       input logic le, input logic [2:0] ls, input logic pc,
                       input logic ill, input logic hlt);
        mem_ready = mr;
        e_rd = rd; e_wr = wr; e_le = le; e_ls = ls; e_pc = pc;
        e_ill = ill; e_hlt = hlt; e_alu = m_alu; e_ret = m_ret;
        exp_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Reset applied between edges: the effect must be visible at once.
    task automatic do_reset();
        rst   = 1'b1;
        m_ret = '0;
        m_alu = '0;
        cyc(1'b1, 0, 0, 0, 3'd0, 0, 0, 0);
        rst = 1'b0;
    endtask

    // Full instruction timeline. fw/mw: cycles with mem_ready low before the
    // ready cycle in fetch/memory phase. abort: reset while waiting in MEM.
    task automatic run_instr(input logic [OS-1:0] op, input int fw, input int mw,
                             input logic zf, input logic abort);
        logic is_mem, is_exec, legal;
        instr = {op, 14'($urandom)};
        flags = {3'b110, zf};
        is_mem  = (op == 5'h01 || op == 5'h02 || op == 5'h03 || op == 5'h04);
        is_exec = (op == 5'h05 || op == 5'h06 || op == 5'h07);
        legal   = is_mem || is_exec || op == 5'h00 || op == 5'h1F;
        // Fetch
        for (int i = 0; i < fw; i++) cyc(1'b0, 1, 0, 0, 3'd0, 0, 0, 0);
        cyc(1'b1, 1, 0, 0, 3'd0, 0, 0, 0);
        // Instruction register load
        cyc(1'b1, 0, 0, 1, 3'd1, 1, 0, 0);
        // Decode: opcode becomes visible on alu_op after this cycle
        cyc(1'b1, 0, 0, 0, 3'd0, 0, !legal, 0);
        m_alu = op;
        if (!is_mem && !is_exec) begin
            m_ret = m_ret + 1'b1;   // NOP, illegal, HLT retire here
            return;
        end
        if (is_mem) begin
            for (int i = 0; i < mw; i++)
                cyc(1'b0, op != 5'h04, op == 5'h04, 0, 3'd0, 0, 0, 0);
            if (abort) begin
                do_reset();
                return;
            end
            cyc(1'b1, op != 5'h04, op == 5'h04, 0, 3'd0, 0, 0, 0);
            if (op != 5'h04) begin
                cyc(1'b1, 0, 0, 1, (op == 5'h01) ? 3'd2 : (op == 5'h02) ? 3'd3 : 3'd4,
                    0, 0, 0);
            end
            m_ret = m_ret + 1'b1;
            return;
        end
        // Execute
        case (op)
            5'h05:   cyc(1'b1, 0, 0, 1, 3'd4, 0, 0, 0);
            5'h06:   cyc(1'b1, 0, 0, 1, 3'd0, 0, 0, 0);
            default: cyc(1'b1, 0, 0, zf, 3'd0, 0, 0, 0);
        endcase
        m_ret = m_ret + 1'b1;
    endtask

    initial begin
        rst       = 1'b1;
        instr     = '0;
        flags     = '0;
        mem_ready = 1'b0;
        m_ret     = '0;
        m_alu     = '0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // NOP straight out of reset
        run_instr(5'h00, 0, 0, 0, 0);
        chk("lit_retired_after_first_nop", int'(retired), 1);
        run_instr(5'h00, 2, 0, 0, 0);

        // Loads and stores, with and without memory wait states
        run_instr(5'h01, 0, 0, 0, 0);
        rd_cnt = 0;
        run_instr(5'h02, 0, 3, 0, 0);
        chk("lit_ldb_mem_rd_cycles", rd_cnt, 5);   // 1 fetch + 4 in MEM
        run_instr(5'h03, 1, 1, 0, 0);
        run_instr(5'h04, 0, 0, 0, 0);
        run_instr(5'h04, 1, 2, 0, 0);

        // ALU and jumps
        run_instr(5'h05, 0, 0, 0, 0);
        run_instr(5'h06, 0, 0, 0, 0);
        run_instr(5'h07, 0, 0, 1, 0);
        run_instr(5'h07, 0, 0, 0, 0);
        chk("lit_retired_after_eleven", int'(retired), 11);

        // Undefined opcodes
        run_instr(5'h0A, 0, 0, 0, 0);
        run_instr(5'h1E, 0, 0, 0, 0);

        // Reset in the middle of a read and of a write
        run_instr(5'h01, 0, 2, 0, 1);
        run_instr(5'h00, 0, 0, 0, 0);
        run_instr(5'h04, 0, 1, 0, 1);
        run_instr(5'h05, 0, 0, 0, 0);
        chk("lit_retired_after_abort", int'(retired), 1);

        // Halt persists for 20 cycles, reset recovers
        run_instr(5'h1F, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) cyc(1'($urandom), 0, 0, 0, 3'd0, 0, 0, 1);
        chk("lit_halted_held", int'(halted), 1);
        do_reset();
        chk("lit_retired_after_reset", int'(retired), 0);
        run_instr(5'h00, 0, 0, 0, 0);

        // Counter wrap
        do_reset();
        for (int i = 0; i < 255; i++) run_instr(5'h00, 0, 0, 0, 0);
        chk("lit_retired_all_ones", int'(retired), 255);
        run_instr(5'h00, 0, 0, 0, 0);
        chk("lit_retired_wrapped", int'(retired), 0);

        exp_valid = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 Parameter WORD_SIZE, default 19, width of instruction word (matches constants package).
REQ-002 Parameter OPCODE_SIZE, default 5, opcode field width = instr[WORD_SIZE-1 -: OPCODE_SIZE].
REQ-003 Parameter CNT_WIDTH, default 16, width of retired-instruction counter.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 instr  input  WORD_SIZE  current IR contents from datapath.
REQ-007 flags  input  4  flag register; flags[0] = zero flag.
REQ-008 mem_ready  input  1  memory completes current read/write this cycle.
REQ-009 mem_rd  output  1  memory read request, held until mem_ready.
REQ-010 mem_wr  output  1  memory write request, held until mem_ready.
REQ-011 load_en  output  1  one-cycle register load strobe.
REQ-012 load_select  output  3  LOAD_SELECT code (LOAD_PC/IR/REG_A/REG_B/REG_C) of target register; valid when load_en=1.
REQ-013 pc_inc  output  1  one-cycle PC increment strobe.
REQ-014 alu_op  output  OPCODE_SIZE  latched opcode driven to ALU.
REQ-015 illegal  output  1  one-cycle pulse on undefined opcode.
REQ-016 halted  output  1  high while in HALT.
REQ-017 retired  output  CNT_WIDTH  count of completed instructions.

Function
REQ-018 States SHALL be FETCH, LOAD_IR, DECODE, MEM, WB, EXEC, HALT; outputs decoded from state and latched opcode op_q only (Moore).
REQ-019 Opcodes: 00 NOP, 01 LDA, 02 LDB, 03 LDC, 04 STA, 05 ADD, 06 JMP, 07 JZ, 1F HLT; all others illegal.
REQ-020 FETCH: mem_rd=1; mem_ready=1 -> LOAD_IR, else stay.
REQ-021 LOAD_IR: load_en=1, load_select=LOAD_IR, pc_inc=1 for exactly one cycle -> DECODE.
REQ-022 DECODE: op_q <= instr opcode field; NOP/illegal -> FETCH; LDA/LDB/LDC/STA -> MEM; ADD/JMP/JZ -> EXEC; HLT -> HALT.
REQ-023 DECODE with illegal opcode: illegal=1 for that one cycle; treated as NOP (retired increments).
REQ-024 MEM: mem_rd=1 for LDx, mem_wr=1 for STA; never both; mem_ready=1 -> WB for LDx, FETCH for STA; else stay.
REQ-025 Every memory access SHALL take at least one cycle in FETCH/MEM even if mem_ready is already high on entry.
REQ-026 WB: load_en=1, load_select=LOAD_REG_A/B/C for LDA/LDB/LDC -> FETCH.
REQ-027 EXEC ADD: alu_op=op_q, load_en=1, load_select=LOAD_REG_C -> FETCH.
REQ-028 EXEC JMP: load_en=1, load_select=LOAD_PC -> FETCH.
REQ-029 EXEC JZ: if flags[0]=1 sample in EXEC, load_en=1, load_select=LOAD_PC; else load_en=0; -> FETCH.
REQ-030 HALT: all strobes 0, halted=1, remain until rst.
REQ-031 retired SHALL increment by 1 on each transition into FETCH from DECODE/MEM/WB/EXEC, and on DECODE->HALT; wraps from all-ones to 0.
REQ-032 load_en, pc_inc, illegal SHALL never be high for two consecutive cycles.
REQ-033 Cycle counts (mem_ready=1 on first request cycle): NOP 3, ADD/JMP/JZ 4, STA 4, LDx 5.

Reset
REQ-034 rst=1 SHALL immediately (asynchronously) force state FETCH, op_q=0, retired=0.
REQ-035 During rst: mem_rd=0, mem_wr=0, load_en=0, pc_inc=0, illegal=0, halted=0, alu_op=0, load_select=LOAD_PC.
REQ-036 Reset asserted mid-MEM SHALL drop mem_rd/mem_wr without waiting for mem_ready; first cycle after release SHALL be FETCH with mem_rd=1.

Verification
REQ-037 Reset release, mem_ready held 1, instr=NOP -> mem_rd cycle 1, load_en+LOAD_IR+pc_inc cycle 2, retired=1 after cycle 3.
REQ-038 instr LDB, mem_ready low 3 cycles in MEM -> mem_rd held 4 cycles, then single load_en with load_select=011.
REQ-039 JZ with flags=0001 -> load_en, load_select=000 in EXEC; flags=0000 -> no load_en, next state FETCH.
REQ-040 Opcode 0x0A -> illegal pulse 1 cycle in DECODE, retired increments, return to FETCH.
REQ-041 HLT -> halted=1 persists 20 cycles with mem_rd=0; rst pulse -> FETCH, retired=0.
REQ-042 Preload retired=0xFFFF via 65535 NOPs, one more NOP -> retired=0x0000.
